// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access controller: sizes, FSM states, ack latencies.
// Round-robin arbitration is selected with the DMEM_ARB_RR_EN macro (see dmem_req_arbiter).
package dmem_pkg;

    localparam logic [1:0] SZ_WORD       = 2'b00;
    localparam logic [1:0] SZ_BYTE_U     = 2'b01;
    localparam logic [1:0] SZ_BYTE_S     = 2'b10;
    localparam logic [1:0] SZ_BYTE_U_ALT = 2'b11;

    // Cycles from the granting edge to the ack pulse, as seen by a requester.
    localparam int ACK_LAT_BYTE = 2;
    localparam int ACK_LAT_WORD = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC0 = 2'b01,
        ST_ACC1 = 2'b10,
        ST_FIN  = 2'b11
    } dmem_state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic [15:0] wdata;
        logic        port;
    } dmem_req_t;

    // cur is the byte arriving this cycle; lo is the buffered low byte of a word.
    function automatic logic [15:0] form_rdata(input logic [1:0] size,
                                               input logic [7:0] cur,
                                               input logic [7:0] lo);
        logic [15:0] res;
        case (size)
            SZ_WORD:       res = {cur, lo};
            SZ_BYTE_S:     res = {{8{cur[7]}}, cur};
            SZ_BYTE_U:     res = {8'h00, cur};
            SZ_BYTE_U_ALT: res = {8'h00, cur};
            default:       res = {8'h00, cur};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_req_arbiter.sv
// Two-port request arbiter with a one-hot grant.
// DMEM_ARB_RR_EN selects round-robin; otherwise port 0 has fixed priority.
module dmem_req_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

`ifdef DMEM_ARB_RR_EN
    // Reset to 1 so that port 0 wins the first tie.
    logic last_grant_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= 1'b1;
        end else if (accept && (|req)) begin
            last_grant_reg <= gnt[1];
        end
    end

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_grant_reg ? 2'b01 : 2'b10;
        end
    end
`else
    assign gnt = {req[1] & ~req[0], req[0]};

    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n, accept};
`endif

endmodule

// File: rtl/dmem_access_ctrl.sv
// Arbitrates two requesters onto a byte-wide single-port data memory, splitting words into two byte cycles.
// Define DMEM_ARB_RR_EN for round-robin arbitration instead of fixed port-0 priority.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [1:0]        p0_size,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [15:0]       p0_wdata,
    output logic              p0_ack,
    output logic [15:0]       p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [1:0]        p1_size,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [15:0]       p1_wdata,
    output logic              p1_ack,
    output logic [15:0]       p1_rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    dmem_state_t       state_reg;
    dmem_req_t         lat_reg;
    logic [ADDR_W-1:0] lat_addr_reg;
    logic [7:0]        lo_buf_reg;
    logic [1:0]        ack_reg;
    logic              busy_reg;
    logic              mem_en_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [7:0]        mem_wdata_reg;

    logic [1:0]        gnt;
    logic              accept;
    dmem_req_t         sel_req;
    logic [ADDR_W-1:0] sel_addr;

    assign accept = (state_reg == ST_IDLE);

    dmem_req_arbiter u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({p1_req, p0_req}),
        .accept (accept),
        .gnt    (gnt)
    );

    always_comb begin
        sel_req.we    = gnt[1] ? p1_we    : p0_we;
        sel_req.size  = gnt[1] ? p1_size  : p0_size;
        sel_req.wdata = gnt[1] ? p1_wdata : p0_wdata;
        sel_req.port  = gnt[1];
        sel_addr      = gnt[1] ? p1_addr  : p0_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            lat_reg       <= '0;
            lat_addr_reg  <= '0;
            lo_buf_reg    <= '0;
            ack_reg       <= '0;
            busy_reg      <= 1'b0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (|gnt) begin
                        lat_reg       <= sel_req;
                        lat_addr_reg  <= sel_addr;
                        state_reg     <= ST_ACC0;
                        busy_reg      <= 1'b1;
                        mem_en_reg    <= 1'b1;
                        mem_we_reg    <= sel_req.we;
                        mem_addr_reg  <= sel_addr;
                        mem_wdata_reg <= sel_req.wdata[7:0];
                    end
                end
                ST_ACC0: begin
                    if (lat_reg.size == SZ_WORD) begin
                        state_reg     <= ST_ACC1;
                        mem_addr_reg  <= lat_addr_reg + ADDR_W'(1);
                        mem_wdata_reg <= lat_reg.wdata[15:8];
                    end else begin
                        state_reg  <= ST_FIN;
                        mem_en_reg <= 1'b0;
                        mem_we_reg <= 1'b0;
                        ack_reg    <= {lat_reg.port, ~lat_reg.port};
                    end
                end
                ST_ACC1: begin
                    // The byte read in ACC0 arrives now and becomes the low half.
                    lo_buf_reg <= mem_rdata;
                    state_reg  <= ST_FIN;
                    mem_en_reg <= 1'b0;
                    mem_we_reg <= 1'b0;
                    ack_reg    <= {lat_reg.port, ~lat_reg.port};
                end
                ST_FIN: begin
                    state_reg <= ST_IDLE;
                    ack_reg   <= '0;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // mem_rdata carries the last byte during FIN, so load data is formed combinationally there.
    logic [15:0] ld_data;
    logic        fin_load;
    logic [15:0] rdata_w [2];

    assign ld_data  = form_rdata(lat_reg.size, mem_rdata, lo_buf_reg);
    assign fin_load = (state_reg == ST_FIN) && !lat_reg.we;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port_rdata
            assign rdata_w[gi] = (fin_load && (lat_reg.port == gi[0])) ? ld_data : 16'h0000;
        end
    endgenerate

    assign p0_ack    = ack_reg[0];
    assign p1_ack    = ack_reg[1];
    assign p0_rdata  = rdata_w[0];
    assign p1_rdata  = rdata_w[1];
    assign busy      = busy_reg;
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural byte memory.
// Expected arbitration order follows DMEM_ARB_RR_EN when it is defined.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [1:0]  p0_size, p1_size;
    logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_ack, p1_ack, busy, mem_en, mem_we;
    logic [15:0] p0_rdata, p1_rdata, mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;

    logic [7:0]  mem [0:65535];
    logic        pl_we = 1'b0;
    logic [15:0] pl_addr = 16'h0000;
    logic [7:0]  pl_data = 8'h00;

    int total = 0;
    int bad = 0;
    int order_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    dmem_access_ctrl #(.ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-12s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_addr = a; pl_data = d; pl_we = 1'b1;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic issue0(input logic we, input logic [1:0] sz, input logic [15:0] a,
                          input logic [15:0] wd, output logic [15:0] rd, output int lat);
        @(negedge clk);
        p0_we = we; p0_size = sz; p0_addr = a; p0_wdata = wd; p0_req = 1'b1;
        lat = -1; rd = 16'hxxxx;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (p0_ack) begin
                lat = n; rd = p0_rdata;
                break;
            end
        end
        p0_req = 1'b0;
    endtask

    // Both ports start together; each re-requests one idle cycle after its ack until done.
    task automatic race(input int n0, input logic we0, input logic [1:0] sz0, input logic [15:0] a0,
                        input logic [15:0] wd0, input logic [15:0] er0,
                        input int n1, input logic we1, input logic [1:0] sz1, input logic [15:0] a1,
                        input logic [15:0] wd1, input logic [15:0] er1);
        int r0, r1;
        order_q.delete();
        @(negedge clk);
        r0 = n0; r1 = n1;
        p0_we = we0; p0_size = sz0; p0_addr = a0; p0_wdata = wd0; p0_req = (n0 > 0);
        p1_we = we1; p1_size = sz1; p1_addr = a1; p1_wdata = wd1; p1_req = (n1 > 0);
        for (int c = 0; c < 200 && (r0 > 0 || r1 > 0); c++) begin
            @(negedge clk);
            if (p0_ack) begin
                order_q.push_back(0);
                chk("race_p0_rd", 32'(p0_rdata), 32'(er0));
                p0_req = 1'b0; r0--;
            end else if (!p0_req && r0 > 0) begin
                p0_req = 1'b1;
            end
            if (p1_ack) begin
                order_q.push_back(1);
                chk("race_p1_rd", 32'(p1_rdata), 32'(er1));
                p1_req = 1'b0; r1--;
            end else if (!p1_req && r1 > 0) begin
                p1_req = 1'b1;
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
    endtask

    initial begin
        logic [15:0] rd;
        int lat;
`ifdef DMEM_ARB_RR_EN
        int exp_ord1[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
        int exp_ord2[5] = '{0, 1, 0, 0, 0};
`else
        int exp_ord1[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        int exp_ord2[5] = '{0, 0, 0, 0, 1};
`endif
        rst_n = 1'b0;
        p0_req = 0; p0_we = 0; p0_size = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_size = 0; p1_addr = 0; p1_wdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_p0_ack", 32'(p0_ack), 32'd0);
        chk("rst_p1_ack", 32'(p1_ack), 32'd0);
        chk("rst_p0_rd", 32'(p0_rdata), 32'd0);
        chk("rst_p1_rd", 32'(p1_rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);

        preload(16'h0040, 8'h11);
        preload(16'h0041, 8'h22);
        preload(16'h0004, 8'h85);
        preload(16'h0010, 8'h5A);
        preload(16'h0020, 8'hC3);
        @(negedge clk);
        rst_n = 1'b1;

        // Word load aborted by reset while in ACC1.
        @(negedge clk);
        p0_we = 0; p0_size = 2'b00; p0_addr = 16'h0040; p0_req = 1'b1;
        @(negedge clk);
        chk("acc0_en", 32'(mem_en), 32'd1);
        chk("acc0_addr", 32'(mem_addr), 32'h0040);
        @(negedge clk);
        chk("acc1_addr", 32'(mem_addr), 32'h0041);
        rst_n = 1'b0;
        #1;
        chk("abort_en", 32'(mem_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ack", 32'(p0_ack), 32'd0);
        p0_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_noack", 32'(p0_ack), 32'd0);
        rst_n = 1'b1;

        issue0(1'b1, 2'b00, 16'h0002, 16'h1294, rd, lat);
        chk("st_w_lat", 32'(lat), 32'd3);
        chk("st_w_rd", 32'(rd), 32'd0);
        chk("mem2", 32'(mem[16'h0002]), 32'h94);
        chk("mem3", 32'(mem[16'h0003]), 32'h12);
        issue0(1'b0, 2'b00, 16'h0002, 16'h0000, rd, lat);
        chk("ld_w_lat", 32'(lat), 32'd3);
        chk("ld_w_rd", 32'(rd), 32'h1294);

        issue0(1'b0, 2'b01, 16'h0004, 16'h0000, rd, lat);
        chk("ld_bu_lat", 32'(lat), 32'd2);
        chk("ld_bu_rd", 32'(rd), 32'h0085);
        issue0(1'b0, 2'b10, 16'h0004, 16'h0000, rd, lat);
        chk("ld_bs_rd", 32'(rd), 32'hFF85);
        issue0(1'b0, 2'b11, 16'h0004, 16'h0000, rd, lat);
        chk("ld_b11_rd", 32'(rd), 32'h0085);

        issue0(1'b1, 2'b00, 16'hFFFF, 16'hABCD, rd, lat);
        chk("wrap_st_lat", 32'(lat), 32'd3);
        chk("memFFFF", 32'(mem[16'hFFFF]), 32'hCD);
        chk("mem0000", 32'(mem[16'h0000]), 32'hAB);
        issue0(1'b0, 2'b00, 16'hFFFF, 16'h0000, rd, lat);
        chk("wrap_ld_rd", 32'(rd), 32'hABCD);

        // Fresh reset so the round-robin pointer starts from its reset value.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        race(4, 1'b0, 2'b01, 16'h0010, 16'h0000, 16'h005A,
             4, 1'b0, 2'b10, 16'h0020, 16'h0000, 16'hFFC3);
        chk("ord1_len", 32'(order_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < order_q.size(); i++)
            chk($sformatf("ord1_%0d", i), 32'(order_q[i]), 32'(exp_ord1[i]));

        race(4, 1'b1, 2'b01, 16'h0030, 16'h0077, 16'h0000,
             1, 1'b0, 2'b10, 16'h0020, 16'h0000, 16'hFFC3);
        chk("ord2_len", 32'(order_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < order_q.size(); i++)
            chk($sformatf("ord2_%0d", i), 32'(order_q[i]), 32'(exp_ord2[i]));
        chk("mem30", 32'(mem[16'h0030]), 32'h77);

        repeat (2) @(negedge clk);
        chk("end_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
